// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bus between the client controllers and the seven-segment arbiter.
interface seg_display_arbiter_if;
    logic [2:0]  req;
    logic [63:0] frame0;
    logic [63:0] frame1;
    logic [63:0] frame2;
    logic [2:0]  grant;
    logic [7:0]  seg_l;
    logic [7:0]  seg_r;
    logic [3:0]  an_l;
    logic [3:0]  an_r;

    modport master (
        output req, frame0, frame1, frame2,
        input  grant, seg_l, seg_r, an_l, an_r
    );

    modport slave (
        input  req, frame0, frame1, frame2,
        output grant, seg_l, seg_r, an_l, an_r
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority display ownership with minimum hold time, plus digit scanning
// of the owner's frame onto both seven-segment banks with per-slot blanking.
module seg_display_arbiter #(
    parameter int unsigned REFRESH_DIV = 200000,
    parameter int unsigned BLANK_CYC   = 2000,
    parameter int unsigned HOLD_CYC    = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_display_arbiter_if.slave  bus
);
    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOCKED, OPEN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          seg_l_q, seg_l_d;
    logic [7:0]          seg_r_q, seg_r_d;
    logic [3:0]          an_q, an_d;

    logic [2:0]          hi_req;
    logic                owner_req;
    logic                higher_req;
    logic                wrap;
    logic [63:0]         frame_sel;
    logic [31:0]         left_half;
    logic [31:0]         right_half;

    // Highest-priority requester and owner/preemption qualifiers.
    always_comb begin
        hi_req = 3'b000;
        if (bus.req[2])      hi_req = 3'b100;
        else if (bus.req[1]) hi_req = 3'b010;
        else if (bus.req[0]) hi_req = 3'b001;
        owner_req  = |(bus.req & grant_q);
        higher_req = |(bus.req & {grant_q[1] | grant_q[0], grant_q[0], 1'b0});
    end

    // Ownership FSM: next state, next grant and hold counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = LOCKED;
                    grant_d = hi_req;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                cnt_d = cnt_q + HOLD_W'(1);
                if (!owner_req) begin
                    state_d = (|bus.req) ? LOCKED : IDLE;
                    grant_d = hi_req;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (!owner_req || higher_req) begin
                    state_d = (|bus.req) ? LOCKED : IDLE;
                    grant_d = hi_req;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    // Scan timing and segment/anode outputs; any owner change restarts at a blank digit 0.
    always_comb begin
        presc_d   = presc_q + PRESC_W'(1);
        idx_d     = idx_q;
        wrap      = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        seg_l_d   = seg_l_q;
        seg_r_d   = seg_r_q;
        frame_sel = '0;
        if (grant_d[2])      frame_sel = bus.frame2;
        else if (grant_d[1]) frame_sel = bus.frame1;
        else if (grant_d[0]) frame_sel = bus.frame0;
        left_half  = frame_sel[31:0];
        right_half = frame_sel[63:32];

        if (grant_d != grant_q) begin
            presc_d = '0;
            idx_d   = 2'd0;
        end else if (wrap) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        if ((grant_d != grant_q) || wrap) begin
            seg_l_d = left_half[{idx_d, 3'b000} +: 8];
            seg_r_d = right_half[{idx_d, 3'b000} +: 8];
        end

        an_d = 4'b0000;
        if ((grant_d != 3'b000) && (presc_d >= PRESC_W'(BLANK_CYC)))
            an_d = 4'b0001 << idx_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            cnt_q   <= '0;
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_l_q <= 8'h00;
            seg_r_q <= 8'h00;
            an_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_l_q <= seg_l_d;
            seg_r_q <= seg_r_d;
            an_q    <= an_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.seg_l = seg_l_q;
    assign bus.seg_r = seg_r_q;
    assign bus.an_l  = an_q;
    assign bus.an_r  = an_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: vector table for steady scanning plus
// hand-written sequences for hold, preemption, drop, frame change and reset.
module tb_seg_display_arbiter;
    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned HOLD  = 20;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] grant;
        logic [7:0] seg_l;
        logic [7:0] seg_r;
        logic [3:0] an;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t exp_q[$];
    vec_t tbl[34];

    logic [63:0] f0     = {32'h4F5B063F, 32'h33796D30};
    logic [63:0] f1_old = {32'h666D7D07, 32'h7F6F777C};
    logic [63:0] f1_new = {32'h395E7971, 32'h3D76301E};
    logic [63:0] f2     = {32'h01020408, 32'h383E776E};

    seg_display_arbiter_if ifc ();

    seg_display_arbiter #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK),
        .HOLD_CYC    (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Expected outputs c cycles after owner g took the display (g=0 means idle).
    function automatic vec_t scan_exp(input logic [2:0] req, input logic [2:0] g,
                                      input logic [63:0] f, input int c);
        vec_t v;
        int p;
        int k;
        p = c % DIV;
        k = (c / DIV) % 4;
        v.req   = req;
        v.grant = g;
        v.seg_l = 8'h00;
        v.seg_r = 8'h00;
        v.an    = 4'b0000;
        if (g != 3'b000) begin
            v.seg_l = f[8*k +: 8];
            v.seg_r = f[32 + 8*k +: 8];
            if (p >= int'(BLANK)) v.an = 4'(1 << k);
        end
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t e);
        checks++;
        if (ifc.grant !== e.grant || ifc.seg_l !== e.seg_l || ifc.seg_r !== e.seg_r ||
            ifc.an_l !== e.an || ifc.an_r !== e.an) begin
            failures++;
            $display("FAIL %s t=%0t: got grant=%b seg_l=%h seg_r=%h an_l=%b an_r=%b, want grant=%b seg_l=%h seg_r=%h an=%b",
                     name, $time, ifc.grant, ifc.seg_l, ifc.seg_r, ifc.an_l, ifc.an_r,
                     e.grant, e.seg_l, e.seg_r, e.an);
        end
    endtask

    // Drive req, queue the expectation for the next edge, then pop and compare.
    task automatic step(input string name, input vec_t e);
        vec_t got;
        ifc.req = e.req;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = exp_q.pop_front();
            check_vec(name, got);
        end
    endtask

    initial begin
        for (int i = 0; i < 34; i++) tbl[i] = scan_exp(3'b001, 3'b001, f0, i);

        reset      = 1'b1;
        ifc.req    = 3'b000;
        ifc.frame0 = f0;
        ifc.frame1 = f1_old;
        ifc.frame2 = f2;
        #3;
        check_vec("reset_state", scan_exp(3'b000, 3'b000, f0, 0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) step("idle", scan_exp(3'b000, 3'b000, f0, 0));

        // Steady scan of owner 0 across a full digit cycle and index wrap.
        for (int i = 0; i < 34; i++) step("scan0", tbl[i]);
        step("drop_to_idle", scan_exp(3'b000, 3'b000, f0, 0));

        // Higher-priority request waits out the hold time.
        for (int c = 0; c < 5; c++) step("hold_pre", scan_exp(3'b001, 3'b001, f0, c));
        for (int c = 5; c <= 20; c++) step("hold_locked", scan_exp(3'b101, 3'b001, f0, c));
        step("preempt", scan_exp(3'b101, 3'b100, f2, 0));
        for (int c = 1; c < 3; c++) step("own2", scan_exp(3'b101, 3'b100, f2, c));

        // Owner drop re-arbitrates immediately, then idle.
        step("drop_rearb", scan_exp(3'b011, 3'b010, f1_old, 0));
        step("drop_idle", scan_exp(3'b000, 3'b000, f0, 0));

        // Frame change mid-slot does not disturb the latched digit.
        for (int c = 0; c < 5; c++) step("f1_old", scan_exp(3'b010, 3'b010, f1_old, c));
        ifc.frame1 = f1_new;
        for (int c = 5; c < 8; c++) step("f1_stable", scan_exp(3'b010, 3'b010, f1_old, c));
        for (int c = 8; c < 13; c++) step("f1_new", scan_exp(3'b010, 3'b010, f1_new, c));

        // Asynchronous reset mid-slot.
        #2;
        reset = 1'b1;
        #1;
        check_vec("async_reset", scan_exp(3'b010, 3'b000, f1_new, 0));
        @(posedge clk);
        #1;
        check_vec("reset_held", scan_exp(3'b010, 3'b000, f1_new, 0));
        @(negedge clk);
        reset = 1'b0;
        step("regrant", scan_exp(3'b010, 3'b010, f1_new, 0));

        // Lower-priority request never preempts, even after the hold expires.
        for (int c = 1; c < 25; c++) step("no_low_preempt", scan_exp(3'b011, 3'b010, f1_new, c));

        // Owner drop together with new requests resolves to the highest.
        step("simul_drop", scan_exp(3'b101, 3'b100, f2, 0));
        step("simul_after", scan_exp(3'b100, 3'b100, f2, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
